// File: rtl/bram_master_pkg.sv
// Shared constants for the block-RAM burst master: FSM encodings and read-FIFO sizing.
package bram_master_pkg;

    localparam int RD_FIFO_DEPTH = 4;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WRITE    = 2'd1;
    localparam logic [1:0] ST_READ     = 2'd2;
    localparam logic [1:0] ST_RD_DRAIN = 2'd3;

endpackage

// File: rtl/bram_rd_fifo.sv
// Small synchronous FIFO that absorbs the RAM read latency so rd_ready backpressure never drops data.
module bram_rd_fifo
    import bram_master_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic [2:0]            count
);

    logic [DATA_WIDTH-1:0] mem_r [RD_FIFO_DEPTH];
    logic [1:0]            wr_ptr_r;
    logic [1:0]            rd_ptr_r;
    logic [2:0]            count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    // Overflow/underflow guards: a push into a full FIFO or a pop from an empty one is dropped.
    assign do_push_s = push && (count_r != 3'(RD_FIFO_DEPTH));
    assign do_pop_s  = pop && (count_r != 3'd0);

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 2'd1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign empty = (count_r == 3'd0);
    assign count = count_r;

endmodule

// File: rtl/bram_burst_master.sv
// Burst initiator for a single-port synchronous block RAM: command port in, RAM pins out,
// write data streamed straight through, read data buffered through bram_rd_fifo.
module bram_burst_master
    import bram_master_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_cs,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  busy,
    output logic                  done
);

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic                  done_r;
    logic                  done_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic                  inflight_r;
    logic                  last_beat_s;
    logic                  wr_beat_s;
    logic                  issue_s;
    logic                  pop_s;
    logic                  fifo_empty_s;
    logic [2:0]            fifo_count_s;
    logic [2:0]            occupancy_s;
    logic                  drain_done_s;

    // Issue only when every outstanding read is guaranteed a FIFO slot; depends on registers only,
    // so rd_ready never reaches mem_cs combinationally.
    assign occupancy_s  = fifo_count_s + {2'b00, inflight_r};
    assign issue_s      = (state_r == ST_READ) && (occupancy_s < 3'(RD_FIFO_DEPTH));
    assign wr_beat_s    = (state_r == ST_WRITE) && wr_valid;
    assign last_beat_s  = (remaining_q == LEN_WIDTH'(0));
    assign pop_s        = rd_valid && rd_ready;
    // Finish in the cycle of the final pop so done lands in the following cycle.
    assign drain_done_s = !inflight_r &&
                          ((fifo_count_s == 3'd0) || ((fifo_count_s == 3'd1) && pop_s));

    // Next-state and done-pulse decode.
    always_comb begin
        state_nxt_s = state_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nxt_s = cmd_write ? ST_WRITE : ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (wr_beat_s && last_beat_s) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_READ: begin
                if (issue_s && last_beat_s) begin
                    state_nxt_s = ST_RD_DRAIN;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_RD_DRAIN: begin
                if (drain_done_s) begin
                    state_nxt_s = ST_IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_RD_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                done_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, done pulse, read-inflight flag, and the address/length counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            done_r      <= 1'b0;
            inflight_r  <= 1'b0;
            addr_q      <= ADDR_WIDTH'(0);
            remaining_q <= LEN_WIDTH'(0);
        end else begin
            state_r    <= state_nxt_s;
            done_r     <= done_nxt_s;
            inflight_r <= issue_s;
            if ((state_r == ST_IDLE) && cmd_valid) begin
                addr_q      <= cmd_addr;
                remaining_q <= cmd_len;
            end else if (wr_beat_s || issue_s) begin
                addr_q      <= addr_q + ADDR_WIDTH'(1);
                remaining_q <= remaining_q - LEN_WIDTH'(1);
            end
        end
    end

    bram_rd_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_r),
        .pop   (pop_s),
        .din   (mem_data_out),
        .dout  (rd_data),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign rd_valid    = !fifo_empty_s;
    assign cmd_ready   = (state_r == ST_IDLE);
    assign busy        = (state_r != ST_IDLE);
    assign wr_ready    = (state_r == ST_WRITE);
    assign done        = done_r;
    assign mem_cs      = wr_beat_s || issue_s;
    assign mem_we      = wr_beat_s;
    assign mem_address = addr_q;
    assign mem_data_in = wr_data;

endmodule
